// File: rtl/bo_datapath.sv
// rtl/bo_datapath.sv - BO datapath: X/S/H registers, operand and write-back muxes, add/sub ULA, status flags
// All commands are sampled every edge; flags are registered for the controller to branch on.
module bo_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             LX,
  input  logic             LS,
  input  logic             LH,
  input  logic             SEL_ULA,
  input  logic [1:0]       M0,
  input  logic [1:0]       M1,
  input  logic [1:0]       M2,
  input  logic             CLR_OVF,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  output logic [WIDTH-1:0] X_OUT,
  output logic [WIDTH-1:0] S_OUT,
  output logic [WIDTH-1:0] H_OUT,
  output logic             H_ZERO,
  output logic             NEG,
  output logic             OVF,
  output logic             LD_ACK
);

  logic [WIDTH-1:0] x_q, s_q, h_q;
  logic [WIDTH-1:0] op_a, op_b, wb, h_next;
  logic [WIDTH:0]   r;
  logic             any_ld, arith_ld;
  logic             h_zero_q, neg_q, ovf_q, ack_q;

  always_comb begin
    case (M0)
      2'b00:   op_a = x_q;
      2'b01:   op_a = s_q;
      2'b10:   op_a = h_q;
      default: op_a = A_IN;
    endcase
  end

  always_comb begin
    case (M1)
      2'b00:   op_b = x_q;
      2'b01:   op_b = h_q;
      2'b10:   op_b = B_IN;
      default: op_b = {{(WIDTH-1){1'b0}}, 1'b1};
    endcase
  end

  // Extra top bit carries the add carry-out or the subtract borrow.
  always_comb begin
    if (SEL_ULA) r = {1'b0, op_a} - {1'b0, op_b};
    else         r = {1'b0, op_a} + {1'b0, op_b};
  end

  always_comb begin
    case (M2)
      2'b00:   wb = r[WIDTH-1:0];
      2'b01:   wb = A_IN;
      2'b10:   wb = B_IN;
      default: wb = '0;
    endcase
  end

  assign any_ld   = LX | LS | LH;
  assign arith_ld = any_ld && (M2 == 2'b00);
  assign h_next   = LH ? wb : h_q;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      x_q      <= '0;
      s_q      <= '0;
      h_q      <= '0;
      h_zero_q <= 1'b1;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      if (LX) x_q <= wb;
      if (LS) s_q <= wb;
      h_q      <= h_next;
      h_zero_q <= (h_next == '0);
      ack_q    <= any_ld;
      if (arith_ld) neg_q <= SEL_ULA ? r[WIDTH] : r[WIDTH-1];
      // A carry/borrow on this edge outranks a simultaneous clear.
      if (arith_ld && r[WIDTH]) ovf_q <= 1'b1;
      else if (CLR_OVF)         ovf_q <= 1'b0;
    end
  end

  assign X_OUT  = x_q;
  assign S_OUT  = s_q;
  assign H_OUT  = h_q;
  assign H_ZERO = h_zero_q;
  assign NEG    = neg_q;
  assign OVF    = ovf_q;
  assign LD_ACK = ack_q;

endmodule

// File: tb/tb_bo_datapath.sv
// tb/tb_bo_datapath.sv - bench for bo_datapath: vector table, async reset sequences, random run vs model
module tb_bo_datapath;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       LX = 0, LS = 0, LH = 0, SEL_ULA = 0, CLR_OVF = 0;
  logic [1:0] M0 = 0, M1 = 0, M2 = 0;
  logic [7:0] A_IN = 0, B_IN = 0;
  logic [7:0] X_OUT, S_OUT, H_OUT;
  logic       H_ZERO, NEG, OVF, LD_ACK;

  bo_datapath #(.WIDTH(8)) dut (
    .clk(clk), .RST(RST), .LX(LX), .LS(LS), .LH(LH), .SEL_ULA(SEL_ULA),
    .M0(M0), .M1(M1), .M2(M2), .CLR_OVF(CLR_OVF), .A_IN(A_IN), .B_IN(B_IN),
    .X_OUT(X_OUT), .S_OUT(S_OUT), .H_OUT(H_OUT), .H_ZERO(H_ZERO),
    .NEG(NEG), .OVF(OVF), .LD_ACK(LD_ACK)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lx, ls, lh, sel;
    logic [1:0] m0, m1, m2;
    logic       clr;
    logic [7:0] a, b;
  } cmd_t;

  typedef struct {
    cmd_t       c;
    logic [7:0] x, s, h;
    logic       hz, neg, ovf, ack;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int m_x, m_s, m_h, m_hz, m_neg, m_ovf, m_ack;
  vec_t tbl[17];

  function automatic cmd_t mkc(logic lx, logic ls, logic lh, logic sel, logic [1:0] m0,
                               logic [1:0] m1, logic [1:0] m2, logic clr, logic [7:0] a, logic [7:0] b);
    cmd_t c;
    c.lx = lx; c.ls = ls; c.lh = lh; c.sel = sel;
    c.m0 = m0; c.m1 = m1; c.m2 = m2; c.clr = clr; c.a = a; c.b = b;
    return c;
  endfunction

  function automatic vec_t mkv(cmd_t c, logic [7:0] x, logic [7:0] s, logic [7:0] h,
                               logic hz, logic neg, logic ovf, logic ack);
    vec_t v;
    v.c = c; v.x = x; v.s = s; v.h = h; v.hz = hz; v.neg = neg; v.ovf = ovf; v.ack = ack;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int x, input int s, input int h,
                         input int hz, input int neg, input int ovf, input int ack);
    chk({tag, " X"}, X_OUT, x);
    chk({tag, " S"}, S_OUT, s);
    chk({tag, " H"}, H_OUT, h);
    chk({tag, " H_ZERO"}, H_ZERO, hz);
    chk({tag, " NEG"}, NEG, neg);
    chk({tag, " OVF"}, OVF, ovf);
    chk({tag, " LD_ACK"}, LD_ACK, ack);
  endtask

  task automatic model_reset();
    m_x = 0; m_s = 0; m_h = 0; m_hz = 1; m_neg = 0; m_ovf = 0; m_ack = 0;
  endtask

  // Applies one command for one clock edge and advances the arithmetic model alongside it.
  task automatic cyc(input cmd_t c);
    int opa_sel[4], opb_sel[4], wb_sel[4];
    int a, b, raw, res, carry, nx, ns, nh, nneg, novf;
    LX = c.lx; LS = c.ls; LH = c.lh; SEL_ULA = c.sel;
    M0 = c.m0; M1 = c.m1; M2 = c.m2; CLR_OVF = c.clr; A_IN = c.a; B_IN = c.b;
    opa_sel = '{m_x, m_s, m_h, int'(c.a)};
    opb_sel = '{m_x, m_h, int'(c.b), 1};
    a = opa_sel[c.m0];
    b = opb_sel[c.m1];
    raw   = c.sel ? a - b : a + b;
    carry = c.sel ? int'(a < b) : int'(raw > 255);
    res   = (raw + 256) % 256;
    wb_sel = '{res, int'(c.a), int'(c.b), 0};
    nx = c.lx ? wb_sel[c.m2] : m_x;
    ns = c.ls ? wb_sel[c.m2] : m_s;
    nh = c.lh ? wb_sel[c.m2] : m_h;
    nneg = m_neg;
    novf = m_ovf;
    if ((c.lx || c.ls || c.lh) && c.m2 == 2'b00) begin
      nneg = c.sel ? carry : int'(res >= 128);
      if (carry != 0) novf = 1;
      else if (c.clr) novf = 0;
    end else if (c.clr) novf = 0;
    @(posedge clk);
    #1;
    m_x = nx; m_s = ns; m_h = nh; m_hz = int'(nh == 0);
    m_neg = nneg; m_ovf = novf; m_ack = int'(c.lx || c.ls || c.lh);
  endtask

  task automatic async_reset_check(input string tag);
    #2 RST = 1'b0;
    #1 model_reset();
    chk_all(tag, 0, 0, 0, 1, 0, 0, 0);
    #1 RST = 1'b1;
  endtask

  initial begin
    cmd_t c;
    model_reset();

    tbl[0]  = mkv(mkc(1,0,1,0, 2'b00,2'b00,2'b01, 0, 8'd5, 8'd0),   8'd5,  8'h00, 8'd5, 0,0,0,1);
    tbl[1]  = mkv(mkc(0,0,0,0, 2'b00,2'b00,2'b00, 0, 8'd0, 8'd0),   8'd5,  8'h00, 8'd5, 0,0,0,0);
    tbl[2]  = mkv(mkc(0,0,1,1, 2'b10,2'b11,2'b00, 0, 8'd0, 8'd0),   8'd5,  8'h00, 8'd4, 0,0,0,1);
    tbl[3]  = mkv(mkc(0,0,1,1, 2'b10,2'b11,2'b00, 0, 8'd0, 8'd0),   8'd5,  8'h00, 8'd3, 0,0,0,1);
    tbl[4]  = mkv(mkc(0,0,1,1, 2'b10,2'b11,2'b00, 0, 8'd0, 8'd0),   8'd5,  8'h00, 8'd2, 0,0,0,1);
    tbl[5]  = mkv(mkc(0,0,1,1, 2'b10,2'b11,2'b00, 0, 8'd0, 8'd0),   8'd5,  8'h00, 8'd1, 0,0,0,1);
    tbl[6]  = mkv(mkc(0,0,1,1, 2'b10,2'b11,2'b00, 0, 8'd0, 8'd0),   8'd5,  8'h00, 8'd0, 1,0,0,1);
    tbl[7]  = mkv(mkc(0,1,0,0, 2'b00,2'b00,2'b10, 0, 8'd0, 8'hF0),  8'd5,  8'hF0, 8'd0, 1,0,0,1);
    tbl[8]  = mkv(mkc(0,1,0,0, 2'b01,2'b10,2'b00, 0, 8'd0, 8'h20),  8'd5,  8'h10, 8'd0, 1,0,1,1);
    tbl[9]  = mkv(mkc(0,0,0,0, 2'b00,2'b00,2'b00, 1, 8'd0, 8'd0),   8'd5,  8'h10, 8'd0, 1,0,0,0);
    tbl[10] = mkv(mkc(1,0,0,0, 2'b00,2'b00,2'b01, 0, 8'd3, 8'd0),   8'd3,  8'h10, 8'd0, 1,0,0,1);
    tbl[11] = mkv(mkc(1,0,0,1, 2'b00,2'b10,2'b00, 0, 8'd0, 8'd7),   8'hFC, 8'h10, 8'd0, 1,1,1,1);
    tbl[12] = mkv(mkc(0,0,0,0, 2'b00,2'b00,2'b00, 1, 8'd0, 8'd0),   8'hFC, 8'h10, 8'd0, 1,1,0,0);
    tbl[13] = mkv(mkc(1,0,1,0, 2'b00,2'b00,2'b01, 0, 8'd2, 8'd0),   8'd2,  8'h10, 8'd2, 0,1,0,1);
    tbl[14] = mkv(mkc(1,1,0,0, 2'b00,2'b00,2'b00, 0, 8'd0, 8'd0),   8'd4,  8'h04, 8'd2, 0,0,0,1);
    tbl[15] = mkv(mkc(0,0,1,0, 2'b11,2'b11,2'b00, 1, 8'hFF, 8'd0),  8'd4,  8'h04, 8'd0, 1,0,1,1);
    tbl[16] = mkv(mkc(1,1,1,0, 2'b00,2'b00,2'b11, 0, 8'd9, 8'd9),   8'd0,  8'h00, 8'd0, 1,0,1,1);

    repeat (2) @(posedge clk);
    #1 chk_all("reset", 0, 0, 0, 1, 0, 0, 0);
    RST = 1'b1;

    // Fill every register with 0x5A, then drop reset mid-cycle with no clock edge.
    cyc(mkc(1,1,1,0, 2'b00,2'b00,2'b01, 0, 8'h5A, 8'h00));
    chk_all("preload", 8'h5A, 8'h5A, 8'h5A, 0, 0, 0, 1);
    async_reset_check("async_reset");

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].c);
      chk_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].s, tbl[i].h,
              tbl[i].hz, tbl[i].neg, tbl[i].ovf, tbl[i].ack);
    end

    // Reset in the middle of a continuous load stream; first load after release acts at once.
    cyc(mkc(1,0,0,0, 2'b11,2'b10,2'b00, 0, 8'h80, 8'h90));
    chk_all("stream", m_x, m_s, m_h, m_hz, m_neg, m_ovf, m_ack);
    async_reset_check("midrun_reset");
    cyc(mkc(0,1,0,0, 2'b00,2'b00,2'b10, 0, 8'h00, 8'h33));
    chk_all("first_after_reset", 0, 8'h33, 0, 1, 0, 0, 1);
    model_reset();
    m_s = 8'h33; m_ack = 1;

    for (int i = 0; i < 400; i++) begin
      c = mkc(1'($urandom_range(0,2) == 0), 1'($urandom_range(0,2) == 0), 1'($urandom_range(0,2) == 0),
              1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom_range(0,4) == 0 ? 1 : 0),
              1'($urandom_range(0,3) == 0), 8'($urandom), 8'($urandom));
      if (i % 3 == 0) c.m2 = 2'($urandom);
      cyc(c);
      chk_all($sformatf("rand%0d", i), m_x, m_s, m_h, m_hz, m_neg, m_ovf, m_ack);
      if ($urandom_range(0, 59) == 0) async_reset_check($sformatf("rand_reset%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
